// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmitter and receiver:
//     - uart_state_e     : frame state encoding (IDLE, START, DATA, STOP)
//     - DEFAULT_CLK_HZ   : default system clock frequency in Hz
//     - DEFAULT_BAUD     : default line bit rate
//     - clks_per_bit()   : clock cycles per line bit (integer division)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DEFAULT_CLK_HZ = 65_000_000;
    localparam int DEFAULT_BAUD   = 115_200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 serial receiver sharing the transmitter's baud constants. The line is
//   synchronised through two flops, a falling edge in IDLE is confirmed at the
//   middle of the start bit, and each data bit and the stop bit are sampled at
//   their middles.
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst       in   1  synchronous reset, active low
//   RxD       in   1  serial line, idle high
//   RxData    out  8  last byte received with a valid stop bit
//   rx_valid  out  1  one-cycle pulse when RxData is updated
//   state_dbg out  2  current frame state, for observation only
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ,
    parameter int BAUD   = DEFAULT_BAUD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RxD,
    output logic [7:0]  RxData,
    output logic        rx_valid,
    output uart_state_e state_dbg
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_rx: CLK_HZ/BAUD must be at least 2");
    end

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             s1_q, s2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!s2_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    // A glitch shorter than half a bit is not a start bit.
                    state_d = s2_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {s2_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (s2_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            s1_q    <= RxD;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign RxData    = data_q;
    assign rx_valid  = valid_q;
    assign state_dbg = state_q;

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   8N1 serial transmitter. One byte per valid/ready handshake; the line idles
//   high, sends a low start bit, eight data bits LSB first and a high stop bit,
//   each held for CLKS_PER_BIT = CLK_HZ/BAUD clock cycles.
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst       in   1  synchronous reset, active low
//   tx_data   in   8  byte to send, sampled only on the accept edge
//   tx_valid  in   1  sender has a byte on tx_data
//   tx_ready  out  1  block can accept a byte this cycle
//   TxD       out  1  serial line (registered, idle high)
//   tx_busy   out  1  a frame is in progress
//   state_dbg out  2  current frame state, for observation only
//
// Handshake: a byte is taken on a rising edge where tx_valid and tx_ready are
// both 1. tx_valid while tx_ready is 0 is simply ignored (nothing is queued),
// so the sender must hold tx_valid until it sees tx_ready.
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ,
    parameter int BAUD   = DEFAULT_BAUD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        TxD,
    output logic        tx_busy,
    output uart_state_e state_dbg
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx: CLK_HZ/BAUD must be at least 2");
    end

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             bit_done;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        bit_done = (cnt_q == CNT_LAST);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (tx_valid && ready_q) begin
                    shift_d = tx_data;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    // Next bit moves into shift_q[0], which drives the line.
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Line level is decoded from the next state so the flop shows the new
        // bit on the same edge the state changes (start bit right after accept).
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign TxD       = txd_q;
    assign tx_ready  = ready_q;
    assign tx_busy   = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = 10;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        TxD;
  logic        tx_busy;
  uart_state_e tx_state;
  logic [7:0]  rx_data;
  logic        rx_valid;
  uart_state_e rx_state;

  always #5 clk = ~clk;

  uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .TxD       (TxD),
    .tx_busy   (tx_busy),
    .state_dbg (tx_state)
  );

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) rx (
    .clk       (clk),
    .rst       (rst),
    .RxD       (TxD),
    .RxData    (rx_data),
    .rx_valid  (rx_valid),
    .state_dbg (rx_state)
  );

  // ---------------- counters / check helper ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // The line is modelled as a list of future bit levels: an accepted byte
  // appends its whole 10-bit frame, each bit repeated CPB times; one level is
  // consumed per clock. The block is ready whenever nothing is left to send.
  logic       m_line[$];
  logic [7:0] exp_q[$];
  logic       exp_txd   = 1'b1;
  logic       exp_ready = 1'b0;
  logic       exp_busy  = 1'b0;
  bit         model_on  = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_line.delete();
      exp_q.delete();
      exp_txd   = 1'b1;
      exp_ready = 1'b0;
      exp_busy  = 1'b0;
    end else begin
      if (exp_ready && tx_valid) begin
        for (int b = 0; b < 10; b++) begin
          logic lvl;
          lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : tx_data[b-1];
          for (int c = 0; c < CPB; c++) m_line.push_back(lvl);
        end
        exp_q.push_back(tx_data);
      end
      if (m_line.size() > 0) begin
        exp_txd   = m_line.pop_front();
        exp_ready = 1'b0;
        exp_busy  = 1'b1;
      end else begin
        exp_txd   = 1'b1;
        exp_ready = 1'b1;
        exp_busy  = 1'b0;
      end
    end
    model_on = 1'b1;
  end

  // ---------------- compare process / scoreboard ----------------
  int         cyc = 0;
  int         falls[$];
  logic       prev_txd = 1'b1;
  int         rx_count = 0;
  logic [7:0] last_rx = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (model_on) begin
      check("txd", 32'(TxD), 32'(exp_txd));
      check("tx_ready", 32'(tx_ready), 32'(exp_ready));
      check("tx_busy", 32'(tx_busy), 32'(exp_busy));
      if (prev_txd === 1'b1 && TxD === 1'b0) falls.push_back(cyc);
      prev_txd = TxD;
      if (rx_valid === 1'b1) begin
        rx_count++;
        last_rx = rx_data;
        if (exp_q.size() > 0) begin
          check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end else begin
          n_checks++;
          $display("FAIL rx_unexpected: got byte %0h, expected no byte", rx_data);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents a byte and returns just after the accepting edge; tx_valid is
  // left high so the caller decides when to drop it.
  task automatic send(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (tx_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL accept_timeout: byte %0h not accepted within 300 cycles", b);
    end
  endtask

  task automatic idle_cycles(input int n);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

  // ---------------- directed tests ----------------
  logic line_a5 [1:101];
  logic rdy_a5  [1:101];
  int   rx_before;

  initial begin
    // Reset held for 5 cycles.
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_txd", 32'(TxD), 32'd1);
    check("reset_ready", 32'(tx_ready), 32'd0);
    check("reset_busy", 32'(tx_busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("release_ready", 32'(tx_ready), 32'd1);
    check("release_txd", 32'(TxD), 32'd1);
    repeat (3) @(negedge clk);

    // 0xA5: pin the waveform with literal values (cycle k = k-th cycle after accept).
    send(8'hA5);
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      if (k == 1) tx_valid = 1'b0;
      line_a5[k] = TxD;
      rdy_a5[k]  = tx_ready;
    end
    check("a5_start_c1", 32'(line_a5[1]), 32'd0);
    check("a5_start_c10", 32'(line_a5[10]), 32'd0);
    check("a5_bit0_c11", 32'(line_a5[11]), 32'd1);
    check("a5_bit0_c20", 32'(line_a5[20]), 32'd1);
    check("a5_bit1_c21", 32'(line_a5[21]), 32'd0);
    check("a5_bit2_c31", 32'(line_a5[31]), 32'd1);
    check("a5_bit3_c41", 32'(line_a5[41]), 32'd0);
    check("a5_bit4_c51", 32'(line_a5[51]), 32'd0);
    check("a5_bit5_c61", 32'(line_a5[61]), 32'd1);
    check("a5_bit6_c71", 32'(line_a5[71]), 32'd0);
    check("a5_bit7_c90", 32'(line_a5[90]), 32'd1);
    check("a5_stop_c91", 32'(line_a5[91]), 32'd1);
    check("a5_stop_c100", 32'(line_a5[100]), 32'd1);
    check("a5_ready_c100", 32'(rdy_a5[100]), 32'd0);
    check("a5_ready_c101", 32'(rdy_a5[101]), 32'd1);
    idle_cycles(10);

    // Back-to-back 0x00 then 0xFF with tx_valid held.
    falls.delete();
    send(8'h00);
    send(8'hFF);
    idle_cycles(120);
    check("b2b_fall_count", 32'(falls.size()), 32'd2);
    if (falls.size() == 2) check("b2b_spacing", 32'(falls[1] - falls[0]), 32'd101);

    // Ignore-while-busy: 0xC3 pulse during the 0x3C frame is dropped.
    rx_before = rx_count;
    send(8'h3C);
    idle_cycles(30);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (180) @(negedge clk);
    check("busy_rx_count", 32'(rx_count - rx_before), 32'd1);
    check("busy_rx_byte", 32'(last_rx), 32'h3C);

    // Reset during data bit 3 of 0x55 (cycles 41..50 after accept).
    send(8'h55);
    idle_cycles(45);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_txd", 32'(TxD), 32'd1);
    check("midrst_ready", 32'(tx_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_release_ready", 32'(tx_ready), 32'd1);
    rx_before = rx_count;
    send(8'h81);
    idle_cycles(120);
    check("after_rst_rx_count", 32'(rx_count - rx_before), 32'd1);
    check("after_rst_rx_byte", 32'(last_rx), 32'h81);

    // Loopback 0x5A.
    rx_before = rx_count;
    send(8'h5A);
    idle_cycles(120);
    check("loop_rx_count", 32'(rx_count - rx_before), 32'd1);
    check("loop_rx_byte", 32'(last_rx), 32'h5A);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
